burst_read_wf: RTL and testbench
================================

Name: burst_read_wf

Overview:
Avalon-MM burst read master, the read-side counterpart of burst_write_wf. A control-port start issues one burst read of ctrl_burstcount words from ctrl_baseaddress. Returned readdata beats are captured into an internal show-ahead FIFO, which a user-side consumer drains. It sits between a DMA/frame controller and the SDRAM/HPS bridge interconnect.

Parameters:
ADDRESS_WIDTH, 32, byte address width.
DATA_WIDTH, 32, word width.
BYTE_ENABLE_WIDTH, 4, equals DATA_WIDTH/8.
BURST_COUNT, 8, maximum burst length.
BURST_WIDTH, 4, equals log2(BURST_COUNT)+1.
FIFO_DEPTH, 16, buffer words; must be at least BURST_COUNT, power of 2.
FIFO_DEPTH_LOG2, 4, equals log2(FIFO_DEPTH).

Ports:
clk  in  1  single clock domain.
reset  in  1  synchronous, active-low; the block is in reset while reset==0.
master_address  out  ADDRESS_WIDTH  burst start byte address.
master_read  out  1  read request.
master_byteenable  out  BYTE_ENABLE_WIDTH  all ones during a request.
master_burstcount  out  BURST_WIDTH  burst length.
master_waitrequest  in  1  interconnect stall.
master_readdata  in  DATA_WIDTH  returned word.
master_readdatavalid  in  1  readdata qualifier.
ctrl_start  in  1  start a burst; sampled in IDLE only.
ctrl_baseaddress  in  ADDRESS_WIDTH  start address.
ctrl_burstcount  in  BURST_WIDTH  words, 1..BURST_COUNT.
ctrl_busy  out  1  high in any state other than IDLE.
ctrl_done  out  1  one-cycle pulse when the last beat is written to the FIFO.
user_read_buffer  in  1  pop request.
user_buffer_data  out  DATA_WIDTH  FIFO head word; valid while user_data_available==1.
user_data_available  out  1  FIFO not empty.

Behaviour:
- Reset values: master_read, ctrl_busy, ctrl_done, user_data_available = 0. master_address, master_burstcount, master_byteenable = 0. FIFO empty. FSM in IDLE.
- FSM state IDLE:
  - On ctrl_start=1 with ctrl_burstcount in 1..BURST_COUNT: latch address and count, go to ARB.
  - A count of 0 or a count above BURST_COUNT is ignored; the FSM stays in IDLE and ctrl_done stays low.
- FSM state ARB:
  - Wait until free space >= latched count, where free space = FIFO_DEPTH - fill.
  - Then go to REQ.
- FSM state REQ:
  - master_read=1; address, burstcount and byteenable=all ones are driven from registers.
  - These signals are held stable while master_waitrequest=1.
  - Leave REQ the cycle after the first clk edge that samples waitrequest=0; go to DATA.
- FSM state DATA:
  - master_read=0.
  - Each readdatavalid beat pushes readdata into the FIFO and decrements the beat counter.
  - On the final beat, go to IDLE and assert ctrl_done in the following cycle.
  - ctrl_busy drops in the same cycle ctrl_done rises.
- Beats may arrive back-to-back at full rate. Beats may also arrive in the same cycle the request is accepted, with zero-latency slaves. Both cases must be counted.
- master_readdatavalid in IDLE, ARB or REQ is dropped and does not affect the FIFO.
- ctrl_start while busy is ignored; there is no queuing.
- FIFO behaviour:
  - Synchronous, show-ahead.
  - Pop occurs when user_read_buffer && user_data_available. A pop while empty is ignored.
  - A simultaneous push and pop leaves fill unchanged.
  - Overflow is impossible by construction because of the ARB gating.
  - The fill counter is FIFO_DEPTH_LOG2+1 bits wide.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: a word pushed at edge N is visible on user_buffer_data with user_data_available=1 after edge N.
- Address passes through unmodified. No alignment check is performed; the caller must supply word-aligned addresses.
- Reset mid-operation: FSM returns to IDLE, master_read drops, the FIFO is flushed, and ctrl_done is not pulsed. Outstanding beats arriving after reset are dropped per the IDLE rule.

Optional Feature:
- Macro: BURST_READ_WF_STATS_EN.
- When defined:
  - Adds output stat_stall_cycles [31:0], which counts cycles with master_read && master_waitrequest and saturates at 0xFFFFFFFF.
  - Adds output stat_bursts [15:0], which increments on each ctrl_done and wraps.
  - Both counters are cleared by reset.
- When undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package burst_wf_pkg holds the shared FSM state encoding and the width relations (BURST_WIDTH, FIFO_DEPTH_LOG2), for reuse with burst_write_wf.
- Sub-module burst_read_fifo is the show-ahead sync FIFO (push, pop, data, empty, fill) with the same clk/reset convention.
- The FSM, beat counter and stats remain in the top module.

Test Plan:
1. Basic burst:
   - Stimulus: waitrequest=0; start with addr 0x38000000, count 8; slave returns 8 consecutive beats 0x1..0x8, 2 cycles after the request; user pops continuously.
   - Required response: one request cycle with burstcount=8; ctrl_done pulses once; consumer sees 0x1..0x8 in order; FIFO ends empty.
2. Waitrequest stall:
   - Stimulus: waitrequest held high 5 cycles.
   - Required response: address, burstcount and read stay stable for all 6 request cycles; exactly one request is accepted. With the macro defined, stat_stall_cycles=5.
3. Backpressure:
   - Stimulus: user never pops; run two count-8 bursts with FIFO_DEPTH=16, then a third start.
   - Required response: the FIFO fills to 16. The third start goes busy but holds in ARB with master_read=0 until 8 pops occur, then issues the request.
4. Boundary inputs:
   - Stimulus: start with count 0; start asserted while busy; pop while empty.
   - Required response: no request, no ctrl_done, busy unchanged, FIFO unchanged.
5. Reset mid-burst:
   - Stimulus: assert reset low after 3 of 8 beats; slave keeps sending beats.
   - Required response: outputs return to reset values; later beats are dropped; user_data_available=0; a subsequent burst completes normally.
6. Simultaneous push/pop:
   - Stimulus: with the FIFO wrapping past index 15, pop every cycle during beats.
   - Required response: fill stays constant; data order is preserved across the wrap.

Source files
------------

// File: rtl/burst_wf_pkg.sv
// -----------------------------------------------------------------------------
// burst_wf_pkg
// Shared definitions for the burst_read_wf / burst_write_wf pair.
//   wf_state_t      : FSM state encoding, identical for both directions.
//   burst_width_of  : burst-count port width for a given maximum burst length.
//   depth_log2_of   : pointer width for a power-of-two buffer depth.
// -----------------------------------------------------------------------------
package burst_wf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_REQ  = 2'd2,
    ST_DATA = 2'd3
  } wf_state_t;

  // A burst of N words needs log2(N)+1 bits so that N itself is representable.
  function automatic int burst_width_of(input int burst_count);
    return $clog2(burst_count) + 1;
  endfunction

  function automatic int depth_log2_of(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/burst_read_fifo.sv
// -----------------------------------------------------------------------------
// burst_read_fifo
// Synchronous show-ahead FIFO. The head word is presented combinationally from
// the storage array, so a word written at edge N is on pop_data right after N.
// Ports:
//   clk, reset        : clock, synchronous active-low reset (flushes contents)
//   push, push_data   : write strobe and word (push while full is ignored)
//   pop               : advance the head (pop while empty is ignored)
//   pop_data          : current head word, valid while empty==0
//   empty             : no words stored
//   fill              : number of stored words, 0..DEPTH
// -----------------------------------------------------------------------------
module burst_read_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   fill
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty    = (fill == '0);
  assign do_push  = push && (fill != (DEPTH_LOG2+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers are exactly DEPTH_LOG2 bits wide, so they wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  // Storage needs no reset: a word is only observable after it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/burst_read_wf.sv
// -----------------------------------------------------------------------------
// burst_read_wf
// Avalon-MM burst read master. A ctrl_start issues one read burst of
// ctrl_burstcount words at ctrl_baseaddress; returned beats land in a
// show-ahead FIFO that the user side drains.
//
// Optional build macro: BURST_READ_WF_STATS_EN adds stat_stall_cycles
// (saturating count of stalled request cycles) and stat_bursts (wrapping count
// of completed bursts).
//
// Ports:
//   clk, reset            : single clock, synchronous active-low reset
//   master_*              : Avalon-MM read master (address, read, byteenable,
//                           burstcount, waitrequest, readdata, readdatavalid)
//   ctrl_start            : start a burst (sampled in IDLE only)
//   ctrl_baseaddress      : byte address of the burst, passed through as-is
//   ctrl_burstcount       : words, 1..BURST_COUNT; other values are ignored
//   ctrl_busy             : high whenever the FSM is not IDLE
//   ctrl_done             : one-cycle pulse after the last beat is buffered
//   user_read_buffer      : pop request
//   user_buffer_data      : FIFO head word
//   user_data_available   : FIFO not empty
//
// Handshakes: a request is presented with master_read=1 and held unchanged
// while master_waitrequest=1; it is accepted on the edge that samples
// master_read && !master_waitrequest. master_readdatavalid qualifies
// master_readdata for one beat per cycle, including the acceptance cycle. A
// user word is consumed on the edge that samples
// user_read_buffer && user_data_available.
//
// The FSM state is held in the internal signal 'state' (type wf_state_t).
// -----------------------------------------------------------------------------
module burst_read_wf
  import burst_wf_pkg::*;
#(
  parameter int ADDRESS_WIDTH     = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int BYTE_ENABLE_WIDTH = 4,
  parameter int BURST_COUNT       = 8,
  parameter int BURST_WIDTH       = burst_width_of(BURST_COUNT),
  parameter int FIFO_DEPTH        = 16,
  parameter int FIFO_DEPTH_LOG2   = depth_log2_of(FIFO_DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic [ADDRESS_WIDTH-1:0]     master_address,
  output logic                         master_read,
  output logic [BYTE_ENABLE_WIDTH-1:0] master_byteenable,
  output logic [BURST_WIDTH-1:0]       master_burstcount,
  input  logic                         master_waitrequest,
  input  logic [DATA_WIDTH-1:0]        master_readdata,
  input  logic                         master_readdatavalid,
  input  logic                         ctrl_start,
  input  logic [ADDRESS_WIDTH-1:0]     ctrl_baseaddress,
  input  logic [BURST_WIDTH-1:0]       ctrl_burstcount,
  output logic                         ctrl_busy,
  output logic                         ctrl_done,
  input  logic                         user_read_buffer,
  output logic [DATA_WIDTH-1:0]        user_buffer_data,
  output logic                         user_data_available
`ifdef BURST_READ_WF_STATS_EN
  ,
  output logic [31:0]                  stat_stall_cycles,
  output logic [15:0]                  stat_bursts
`endif
);

  wf_state_t                    state;
  logic [ADDRESS_WIDTH-1:0]     addr_q;
  logic [BURST_WIDTH-1:0]       count_q;
  logic [BURST_WIDTH-1:0]       beats_left;
  logic [BURST_WIDTH-1:0]       remaining;
  logic [FIFO_DEPTH_LOG2:0]     fill;
  logic [FIFO_DEPTH_LOG2:0]     free_space;
  logic                         fifo_empty;
  logic                         start_ok;
  logic                         space_ok;
  logic                         accept;
  logic                         push;
  logic                         pop;
  logic                         last_beat;

  assign start_ok = ctrl_start && (ctrl_burstcount != '0) &&
                    (ctrl_burstcount <= BURST_WIDTH'(BURST_COUNT));

  // Only issue a request once the whole burst is guaranteed to fit, so the
  // FIFO can never overflow regardless of how fast beats come back.
  assign free_space = (FIFO_DEPTH_LOG2+1)'(FIFO_DEPTH) - fill;
  assign space_ok   = free_space >= (FIFO_DEPTH_LOG2+1)'(count_q);

  assign accept = (state == ST_REQ) && !master_waitrequest;

  // A zero-latency slave may return the first beat on the acceptance edge;
  // beats seen while the request is still stalled (or outside a burst) drop.
  assign push = master_readdatavalid && ((state == ST_DATA) || accept);

  // Beats still owed before this cycle's beat: the full count while in REQ.
  assign remaining = (state == ST_REQ) ? count_q : beats_left;
  assign last_beat = push && (remaining == BURST_WIDTH'(1));

  assign pop                 = user_read_buffer && !fifo_empty;
  assign user_data_available = !fifo_empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= ST_IDLE;
      addr_q            <= '0;
      count_q           <= '0;
      beats_left        <= '0;
      master_address    <= '0;
      master_read       <= 1'b0;
      master_byteenable <= '0;
      master_burstcount <= '0;
      ctrl_busy         <= 1'b0;
      ctrl_done         <= 1'b0;
    end else begin
      ctrl_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            addr_q    <= ctrl_baseaddress;
            count_q   <= ctrl_burstcount;
            ctrl_busy <= 1'b1;
            state     <= ST_ARB;
          end
        end
        ST_ARB: begin
          if (space_ok) begin
            master_address    <= addr_q;
            master_burstcount <= count_q;
            master_byteenable <= '1;
            master_read       <= 1'b1;
            state             <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (!master_waitrequest) begin
            master_read       <= 1'b0;
            master_byteenable <= '0;
            if (last_beat) begin
              ctrl_busy <= 1'b0;
              ctrl_done <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              beats_left <= push ? count_q - BURST_WIDTH'(1) : count_q;
              state      <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (push) begin
            beats_left <= beats_left - BURST_WIDTH'(1);
            if (last_beat) begin
              ctrl_busy <= 1'b0;
              ctrl_done <= 1'b1;
              state     <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  burst_read_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (master_readdata),
    .pop       (pop),
    .pop_data  (user_buffer_data),
    .empty     (fifo_empty),
    .fill      (fill)
  );

`ifdef BURST_READ_WF_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_stall_cycles <= '0;
      stat_bursts       <= '0;
    end else begin
      if (master_read && master_waitrequest && (stat_stall_cycles != '1))
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      if (ctrl_done)
        stat_bursts <= stat_bursts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_burst_read_wf.sv
// -----------------------------------------------------------------------------
// tb_burst_read_wf
// Directed bench for burst_read_wf: a table of burst records plus hand-written
// sequences for boundary inputs, backpressure and reset mid-burst. A scoreboard
// queue holds the words the slave returned; every user pop is checked against
// its head. Define BURST_READ_WF_STATS_EN to include the statistics checks.
// -----------------------------------------------------------------------------
module tb_burst_read_wf;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BEW = 4;
  localparam int BC  = 8;
  localparam int BW  = 4;
  localparam int FD  = 16;
  localparam int FDL = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]  master_address;
  logic           master_read;
  logic [BEW-1:0] master_byteenable;
  logic [BW-1:0]  master_burstcount;
  logic           master_waitrequest;
  logic [DW-1:0]  master_readdata;
  logic           master_readdatavalid;
  logic           ctrl_start;
  logic [AW-1:0]  ctrl_baseaddress;
  logic [BW-1:0]  ctrl_burstcount;
  logic           ctrl_busy;
  logic           ctrl_done;
  logic           user_read_buffer;
  logic [DW-1:0]  user_buffer_data;
  logic           user_data_available;
`ifdef BURST_READ_WF_STATS_EN
  logic [31:0]    stat_stall_cycles;
  logic [15:0]    stat_bursts;
`endif

  burst_read_wf #(
    .ADDRESS_WIDTH     (AW),
    .DATA_WIDTH        (DW),
    .BYTE_ENABLE_WIDTH (BEW),
    .BURST_COUNT       (BC),
    .BURST_WIDTH       (BW),
    .FIFO_DEPTH        (FD),
    .FIFO_DEPTH_LOG2   (FDL)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_byteenable    (master_byteenable),
    .master_burstcount    (master_burstcount),
    .master_waitrequest   (master_waitrequest),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .ctrl_start           (ctrl_start),
    .ctrl_baseaddress     (ctrl_baseaddress),
    .ctrl_burstcount      (ctrl_burstcount),
    .ctrl_busy            (ctrl_busy),
    .ctrl_done            (ctrl_done),
    .user_read_buffer     (user_read_buffer),
    .user_buffer_data     (user_buffer_data),
    .user_data_available  (user_data_available)
`ifdef BURST_READ_WF_STATS_EN
    ,
    .stat_stall_cycles    (stat_stall_cycles),
    .stat_bursts          (stat_bursts)
`endif
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  int pop_count  = 0;
  int req_count  = 0;
  int done_count = 0;

  typedef struct {
    logic [AW-1:0] addr;
    int            count;
    logic [DW-1:0] base;
    int            wait_cyc;
    int            lat;
    bit            zero;      // first beat returned on the acceptance edge
    int            pop_mode;  // 0 none, 1 always, 2 only on beat cycles
    bit            keep;      // leave words in the FIFO afterwards
    int            exp_pops;
    int            exp_left;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor runs at the falling edge: values there are what the next rising
  // edge will act on. Inputs are driven 1ns after each rising edge.
  task automatic monitor_sample();
    logic [DW-1:0] e;
    if (reset) begin
      if (user_read_buffer && user_data_available) begin
        pop_count++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_data: actual %0h required <no word expected>", user_buffer_data);
        end else begin
          e = exp_q.pop_front();
          if (user_buffer_data !== e) begin
            errors++;
            $display("FAIL pop_data: actual %0h required %0h", user_buffer_data, e);
          end
        end
      end
      if (master_read && !master_waitrequest) req_count++;
      if (ctrl_done) done_count++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor_sample();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_burst(input logic [AW-1:0] addr, input int count);
    ctrl_start       = 1'b1;
    ctrl_baseaddress = addr;
    ctrl_burstcount  = BW'(count);
    step();
    ctrl_start = 1'b0;
    check("busy_after_start", ctrl_busy, 1);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!master_read && n < 40) begin
      step();
      n++;
    end
    check("request_seen", master_read, 1);
  endtask

  task automatic drain();
    int n = 0;
    user_read_buffer = 1'b1;
    while (user_data_available && n < 40) begin
      step();
      n++;
    end
    user_read_buffer = 1'b0;
    check("drain_empty", user_data_available, 0);
  endtask

  task automatic drive_beat(input logic [DW-1:0] data, input int pop_mode);
    master_readdatavalid = 1'b1;
    master_readdata      = data;
    user_read_buffer     = (pop_mode != 0);
    exp_q.push_back(data);
  endtask

  task automatic idle_beat(input int pop_mode);
    master_readdatavalid = 1'b0;
    user_read_buffer     = (pop_mode == 1);
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int p0, r0, d0, first;
    v  = vecs[idx];
    p0 = pop_count;
    r0 = req_count;
    d0 = done_count;
    user_read_buffer   = (v.pop_mode == 1);
    master_waitrequest = (v.wait_cyc > 0);
    start_burst(v.addr, v.count);
    wait_req();
    check("req_address", master_address, v.addr);
    check("req_burstcount", master_burstcount, v.count);
    check("req_byteenable", master_byteenable, 4'hF);
    for (int w = 0; w < v.wait_cyc; w++) begin
      step();
      check("stall_read", master_read, 1);
      check("stall_address", master_address, v.addr);
      check("stall_burstcount", master_burstcount, v.count);
    end
    master_waitrequest = 1'b0;
    if (v.zero) drive_beat(v.base, v.pop_mode);
    step();
    idle_beat(v.pop_mode);
    check("read_dropped", master_read, 0);
    first = v.zero ? 1 : 0;
    if (!v.zero) begin
      for (int l = 0; l < v.lat; l++) step();
    end
    for (int i = first; i < v.count; i++) begin
      drive_beat(v.base + DW'(i), v.pop_mode);
      step();
    end
    idle_beat(v.pop_mode);
    check("done_pulse", ctrl_done, 1);
    check("busy_cleared", ctrl_busy, 0);
    user_read_buffer = 1'b0;
    step();
    check("done_one_cycle", ctrl_done, 0);
    if (!v.keep) drain();
    check("pops", pop_count - p0, v.exp_pops);
    check("words_left", exp_q.size(), v.exp_left);
    check("available", user_data_available, v.exp_left != 0);
    check("one_request", req_count - r0, 1);
    check("one_done", done_count - d0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    int p0, r0, d0;

    //          addr           cnt base     wait lat zero pop keep pops left
    vecs[0] = '{32'h3800_0000, 8, 32'h1,    0,   2,  0,   1,  0,   8,   0};
    vecs[1] = '{32'h0000_1000, 8, 32'h10,   5,   0,  0,   1,  0,   8,   0};
    vecs[2] = '{32'h2000_0040, 1, 32'hA0,   2,   0,  1,   0,  0,   1,   0};
    vecs[3] = '{32'h0000_0100, 5, 32'hB0,   0,   1,  1,   0,  0,   5,   0};
    vecs[4] = '{32'h1000_0000, 8, 32'h100,  0,   1,  0,   0,  1,   0,   8};
    vecs[5] = '{32'h1000_0020, 8, 32'h200,  1,   0,  0,   0,  1,   0,   16};
    vecs[6] = '{32'h0400_0000, 4, 32'h300,  0,   0,  0,   0,  1,   0,   4};
    vecs[7] = '{32'h0400_0010, 8, 32'h400,  0,   1,  0,   2,  1,   8,   4};
    vecs[8] = '{32'h0400_0030, 8, 32'h500,  3,   0,  1,   2,  0,   12,  0};

    reset                = 1'b0;
    master_waitrequest   = 1'b0;
    master_readdata      = '0;
    master_readdatavalid = 1'b0;
    ctrl_start           = 1'b0;
    ctrl_baseaddress     = '0;
    ctrl_burstcount      = '0;
    user_read_buffer     = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) step();
    check("rst_read", master_read, 0);
    check("rst_busy", ctrl_busy, 0);
    check("rst_done", ctrl_done, 0);
    check("rst_avail", user_data_available, 0);
    check("rst_address", master_address, 0);
    check("rst_burstcount", master_burstcount, 0);
    check("rst_byteenable", master_byteenable, 0);
    reset = 1'b1;
    step();

    // Basic burst and waitrequest stall.
    for (int i = 0; i < 2; i++) run_vec(i);
`ifdef BURST_READ_WF_STATS_EN
    check("stat_stall", stat_stall_cycles, 5);
    check("stat_bursts", stat_bursts, 2);
`endif
    // Zero-latency slaves.
    for (int i = 2; i < 4; i++) run_vec(i);

    // Boundary inputs.
    p0 = pop_count; r0 = req_count; d0 = done_count;
    master_readdatavalid = 1'b1;
    master_readdata      = 32'hDEAD;
    repeat (2) step();
    master_readdatavalid = 1'b0;
    check("idle_beat_dropped", user_data_available, 0);
    ctrl_start = 1'b1; ctrl_baseaddress = 32'h50; ctrl_burstcount = 4'd0;
    step();
    check("count0_busy", ctrl_busy, 0);
    ctrl_burstcount = 4'd9;
    step();
    check("count9_busy", ctrl_busy, 0);
    ctrl_start = 1'b0;
    repeat (3) step();
    check("bad_count_read", master_read, 0);
    user_read_buffer = 1'b1;
    repeat (2) step();
    user_read_buffer = 1'b0;
    check("empty_pop_avail", user_data_available, 0);
    check("bad_inputs_pops", pop_count - p0, 0);
    check("bad_inputs_reqs", req_count - r0, 0);
    check("bad_inputs_done", done_count - d0, 0);

    // Start while busy is ignored.
    start_burst(32'h60, 2);
    wait_req();
    step();
    ctrl_start = 1'b1; ctrl_baseaddress = 32'h9999; ctrl_burstcount = 4'd4;
    drive_beat(32'h61, 0);
    step();
    check("busy_held", ctrl_busy, 1);
    drive_beat(32'h62, 0);
    step();
    ctrl_start = 1'b0;
    idle_beat(0);
    check("busy_start_done", ctrl_done, 1);
    repeat (3) step();
    check("busy_start_read", master_read, 0);
    check("busy_start_idle", ctrl_busy, 0);
    check("busy_start_reqs", req_count - r0, 1);
    check("busy_start_dones", done_count - d0, 1);
    drain();

    // Backpressure: fill to 16, third start must wait in ARB.
    for (int i = 4; i < 6; i++) run_vec(i);
    p0 = pop_count; r0 = req_count;
    start_burst(32'h1000_0040, 8);
    for (int i = 0; i < 4; i++) begin
      step();
      check("arb_hold_read", master_read, 0);
      check("arb_hold_busy", ctrl_busy, 1);
    end
    user_read_buffer = 1'b1;
    repeat (8) step();
    user_read_buffer = 1'b0;
    check("arb_after_pops", master_read, 0);
    step();
    check("arb_release", master_read, 1);
    check("arb_release_addr", master_address, 32'h1000_0040);
    step();
    for (int i = 0; i < 8; i++) begin
      drive_beat(32'h600 + DW'(i), 0);
      step();
    end
    idle_beat(0);
    check("bp_done", ctrl_done, 1);
    drain();
    check("bp_pops", pop_count - p0, 24);
    check("bp_reqs", req_count - r0, 1);

    // Reset in the middle of a burst.
    d0 = done_count;
    start_burst(32'h3800_0100, 8);
    wait_req();
    step();
    for (int i = 0; i < 3; i++) begin
      drive_beat(32'h700 + DW'(i), 0);
      step();
    end
    exp_q.delete();
    drive_beat(32'h703, 0);
    exp_q.delete();
    reset = 1'b0;
    step();
    check("mid_rst_read", master_read, 0);
    check("mid_rst_busy", ctrl_busy, 0);
    check("mid_rst_done", ctrl_done, 0);
    check("mid_rst_avail", user_data_available, 0);
    check("mid_rst_address", master_address, 0);
    check("mid_rst_burstcount", master_burstcount, 0);
`ifdef BURST_READ_WF_STATS_EN
    check("mid_rst_stat_stall", stat_stall_cycles, 0);
    check("mid_rst_stat_bursts", stat_bursts, 0);
`endif
    reset = 1'b1;
    for (int i = 4; i < 8; i++) begin
      master_readdatavalid = 1'b1;
      master_readdata      = 32'h700 + DW'(i);
      step();
    end
    master_readdatavalid = 1'b0;
    step();
    check("late_beats_dropped", user_data_available, 0);
    check("late_beats_busy", ctrl_busy, 0);
    check("mid_rst_no_done", done_count - d0, 0);

    // Normal burst after reset, then push/pop together across the wrap.
    for (int i = 6; i < 9; i++) run_vec(i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
